// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: digit count and hex glyphs.
// Glyphs are active-high {g,f,e,d,c,b,a}; polarity is applied at the top.
// Idle (all-off) levels are given in the same active-high form.
package seg7_scan_driver_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [3:0] AN_OFF  = 4'h0;

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Hex nibble to 7-segment glyph decoder, active-high {g,f,e,d,c,b,a}.
// Purely combinational, zero latency.
// No flow control; output follows input.
module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the glyph for each hex digit
    always_comb begin
        seg = SEG_OFF;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes four hex digits onto a common-anode 4-digit 7-seg display.
// All outputs registered: outputs in cycle t+1 reflect scan state at cycle t.
// No backpressure; inputs are snapshotted once per frame so frames never tear.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_out,
    output logic        frame_start
);

    generate
        if (SCAN_DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_params
            $error("seg7_scan_driver: need SCAN_DIV >= 2 and 1 <= BLANK_CYCLES < SCAN_DIV");
        end
    endgenerate

    localparam int             CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYCLES);

    // Polarity masks: XOR with these turns active-high levels into pin levels
    localparam logic [3:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};

    logic [CW-1:0] cnt;
    logic [1:0]    d;

    logic [15:0] shadow_value;
    logic [3:0]  shadow_en;
    logic [3:0]  shadow_dp;

    logic        frame_edge;
    logic        lit;
    logic [3:0]  cur_nibble;
    logic [6:0]  glyph;
    logic [3:0]  an_hi;
    logic [6:0]  seg_hi;
    logic        dp_hi;

    assign frame_edge = (cnt == '0) && (d == 2'd0);

    // Slot counter and digit index; digit advances when the slot wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            d   <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            d   <= d + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Snapshot the inputs once, at the very start of each frame
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_en    <= '0;
            shadow_dp    <= '0;
        end else if (frame_edge) begin
            shadow_value <= value;
            shadow_en    <= digit_en;
            shadow_dp    <= dp;
        end
    end

    // Only the shadowed nibble of the current digit is decoded
    assign cur_nibble = shadow_value[{d, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble (cur_nibble),
        .seg    (glyph)
    );

    // Active-high view of what the display should show this cycle
    always_comb begin
        lit    = (cnt >= CNT_BLANK) && shadow_en[d];
        an_hi  = AN_OFF;
        seg_hi = SEG_OFF;
        dp_hi  = 1'b0;
        if (lit) begin
            an_hi  = 4'b0001 << d;
            seg_hi = glyph;
            dp_hi  = shadow_dp[d];
        end
    end

    // Register outputs with polarity applied; reset drives the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            an          <= AN_OFF ^ AN_POL;
            seg         <= SEG_OFF ^ SEG_POL;
            dp_out      <= ACTIVE_LOW;
            frame_start <= 1'b0;
        end else begin
            an          <= an_hi ^ AN_POL;
            seg         <= seg_hi ^ SEG_POL;
            dp_out      <= dp_hi ^ ACTIVE_LOW;
            frame_start <= frame_edge;
        end
    end

endmodule
